// File: rtl/param_bus_counter_pkg.sv
// param_bus_counter_pkg: shared state encoding and dir/mode encodings for the bus counter
package param_bus_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } state_e;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/pbc_next_val.sv
// pbc_next_val: combinational next count with wrap or saturate, up or down, in WIDTH+1 bits
module pbc_next_val
    import param_bus_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP    = 1,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dir,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_over
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MAXP1  = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH:0] w_cur;
    logic [WIDTH:0] w_up;
    logic [WIDTH:0] w_dn;
    logic [WIDTH:0] w_dn_wrap;

    // o_over flags a step that would cross the terminal value in the chosen direction
    always_comb begin
        w_cur     = {1'b0, i_data};
        w_up      = w_cur + STEP_W;
        w_dn      = w_cur - STEP_W;
        w_dn_wrap = w_cur + MAXP1 - STEP_W;
        o_over    = (i_dir == DIR_UP) ? (w_up > MAX_W) : (w_cur < STEP_W);
        o_next    = WIDTH'((i_dir == DIR_UP)
                    ? (o_over ? ((i_mode == MODE_SAT) ? MAX_W : w_up - MAXP1) : w_up)
                    : (o_over ? ((i_mode == MODE_SAT) ? '0 : w_dn_wrap) : w_dn));
    end

endmodule

// File: rtl/param_bus_counter.sv
// param_bus_counter: valid/ready counter with wrap or saturate modes, load, clear and disable
module param_bus_counter
    import param_bus_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STEP       = 1,
    parameter int MAX_VAL    = 2**WIDTH-1,
    parameter bit CLR_ON_DIS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dir,
    input  logic             i_mode,
    input  logic             i_data_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_data_valid,
    output logic             o_tc,
    output logic             o_sat
);

    localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MAX_VAL);

    if (STEP < 1 || STEP > MAX_VAL) begin : g_step_check
        $error("param_bus_counter: STEP must lie in 1..MAX_VAL");
    end

    state_e           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_tc;
    logic             r_sat;
    logic [WIDTH-1:0] w_next;
    logic             w_over;
    logic [WIDTH-1:0] w_load;

    pbc_next_val #(
        .WIDTH   (WIDTH),
        .STEP    (STEP),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .i_data (r_data),
        .i_dir  (i_dir),
        .i_mode (i_mode),
        .o_next (w_next),
        .o_over (w_over)
    );

    // loaded values above the terminal count are clamped to it
    always_comb begin
        w_load = ({1'b0, i_load_value} > {1'b0, MAX_D}) ? MAX_D : i_load_value;
    end

    // FSM and registered outputs; tc defaults low so it can only pulse on a wrap edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_tc    <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_clear) begin
                r_data  <= '0;
                r_sat   <= 1'b0;
                r_state <= i_enable ? RUN : IDLE;
                r_valid <= i_enable;
            end else if (i_load) begin
                r_data  <= w_load;
                r_sat   <= 1'b0;
                r_state <= i_enable ? RUN : IDLE;
                r_valid <= i_enable;
            end else if (!i_enable) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_sat   <= 1'b0;
                if (CLR_ON_DIS) r_data <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end
                    RUN: begin
                        if (i_data_ready) begin
                            r_data <= w_next;
                            if (w_over && i_mode == MODE_SAT) begin
                                r_state <= SAT;
                                r_sat   <= 1'b1;
                            end else begin
                                r_tc <= w_over;
                            end
                        end
                    end
                    SAT: begin
                        if (i_mode == MODE_WRAP) begin
                            r_state <= RUN;
                            r_sat   <= 1'b0;
                        end else if (i_data_ready && !w_over) begin
                            r_data  <= w_next;
                            r_state <= RUN;
                            r_sat   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_tc         = r_tc;
    assign o_sat        = r_sat;

endmodule

// File: tb/tb_param_bus_counter.sv
// tb_param_bus_counter: directed checks of count, backpressure, wrap, saturate, disable, priority and reset
module tb_param_bus_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic       dir = 1'b0;
    logic       mode = 1'b0;
    logic       data_ready = 1'b0;

    logic [7:0] d0, d3, d2, dh;
    logic       v0, v3, v2, vh;
    logic       t0, t3, t2, th;
    logic       s0, s3, s2, sh;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_bus_counter u0 (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_clear(clear), .i_load(load),
        .i_load_value(load_value), .i_dir(dir), .i_mode(mode), .i_data_ready(data_ready),
        .o_data(d0), .o_data_valid(v0), .o_tc(t0), .o_sat(s0)
    );

    param_bus_counter #(.STEP(3)) u3 (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_clear(clear), .i_load(load),
        .i_load_value(load_value), .i_dir(dir), .i_mode(mode), .i_data_ready(data_ready),
        .o_data(d3), .o_data_valid(v3), .o_tc(t3), .o_sat(s3)
    );

    param_bus_counter #(.STEP(2)) u2 (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_clear(clear), .i_load(load),
        .i_load_value(load_value), .i_dir(dir), .i_mode(mode), .i_data_ready(data_ready),
        .o_data(d2), .o_data_valid(v2), .o_tc(t2), .o_sat(s2)
    );

    param_bus_counter #(.MAX_VAL(200), .CLR_ON_DIS(1'b0)) uh (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_clear(clear), .i_load(load),
        .i_load_value(load_value), .i_dir(dir), .i_mode(mode), .i_data_ready(data_ready),
        .o_data(dh), .o_data_valid(vh), .o_tc(th), .o_sat(sh)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (d0 !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", d0); end
        checks++;
        if (v0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", v0); end
        checks++;
        if (t0 !== 1'b0 || s0 !== 1'b0) begin failures++; $display("FAIL reset_tc_sat got=%0b%0b exp=00", t0, s0); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (v0 !== 1'b0 || d0 !== 8'd0) begin failures++; $display("FAIL idle_disabled got=v%0b d%0d exp=v0 d0", v0, d0); end
    endtask

    task automatic test_count();
        enable = 1'b1;
        data_ready = 1'b1;
        dir = 1'b0;
        mode = 1'b0;
        tick();
        checks++;
        if (v0 !== 1'b1 || d0 !== 8'd0) begin failures++; $display("FAIL count_start got=v%0b d%0d exp=v1 d0", v0, d0); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (d0 !== 8'(i) || v0 !== 1'b1) begin failures++; $display("FAIL count_%0d got=v%0b d%0d exp=v1 d%0d", i, v0, d0, i); end
        end
    endtask

    task automatic test_backpressure();
        data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (d0 !== 8'd5 || v0 !== 1'b1) begin failures++; $display("FAIL bp_hold_%0d got=v%0b d%0d exp=v1 d5", i, v0, d0); end
        end
        data_ready = 1'b1;
        tick();
        checks++;
        if (d0 !== 8'd6) begin failures++; $display("FAIL bp_resume got=%0d exp=6", d0); end
    endtask

    task automatic test_async_reset();
        repeat (3) tick();
        checks++;
        if (d0 !== 8'd9) begin failures++; $display("FAIL pre_reset_data got=%0d exp=9", d0); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d0 !== 8'd0 || v0 !== 1'b0) begin failures++; $display("FAIL async_reset got=v%0b d%0d exp=v0 d0", v0, d0); end
        checks++;
        if (t0 !== 1'b0 || s0 !== 1'b0) begin failures++; $display("FAIL async_reset_flags got=%0b%0b exp=00", t0, s0); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (d0 !== 8'd0 || v0 !== 1'b1) begin failures++; $display("FAIL reset_resume got=v%0b d%0d exp=v1 d0", v0, d0); end
    endtask

    task automatic test_wrap();
        load = 1'b1;
        load_value = 8'd254;
        tick();
        load = 1'b0;
        checks++;
        if (d0 !== 8'd254 || d3 !== 8'd254) begin failures++; $display("FAIL wrap_load got=%0d,%0d exp=254,254", d0, d3); end
        tick();
        checks++;
        if (d0 !== 8'd255 || t0 !== 1'b0) begin failures++; $display("FAIL wrap_255 got=d%0d tc%0b exp=d255 tc0", d0, t0); end
        checks++;
        if (d3 !== 8'd1 || t3 !== 1'b1) begin failures++; $display("FAIL wrap_step3 got=d%0d tc%0b exp=d1 tc1", d3, t3); end
        tick();
        checks++;
        if (d0 !== 8'd0 || t0 !== 1'b1) begin failures++; $display("FAIL wrap_0 got=d%0d tc%0b exp=d0 tc1", d0, t0); end
        checks++;
        if (d3 !== 8'd4 || t3 !== 1'b0) begin failures++; $display("FAIL wrap_step3_next got=d%0d tc%0b exp=d4 tc0", d3, t3); end
        tick();
        checks++;
        if (d0 !== 8'd1 || t0 !== 1'b0) begin failures++; $display("FAIL wrap_after got=d%0d tc%0b exp=d1 tc0", d0, t0); end
    endtask

    task automatic test_saturate();
        mode = 1'b1;
        dir = 1'b1;
        load = 1'b1;
        load_value = 8'd3;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (d2 !== 8'd1 || s2 !== 1'b0) begin failures++; $display("FAIL sat_step got=d%0d sat%0b exp=d1 sat0", d2, s2); end
        tick();
        checks++;
        if (d2 !== 8'd0 || s2 !== 1'b1 || t2 !== 1'b0) begin failures++; $display("FAIL sat_hit got=d%0d sat%0b tc%0b exp=d0 sat1 tc0", d2, s2, t2); end
        repeat (2) tick();
        checks++;
        if (d2 !== 8'd0 || s2 !== 1'b1 || v2 !== 1'b1) begin failures++; $display("FAIL sat_hold got=d%0d sat%0b v%0b exp=d0 sat1 v1", d2, s2, v2); end
        dir = 1'b0;
        tick();
        checks++;
        if (d2 !== 8'd2 || s2 !== 1'b0) begin failures++; $display("FAIL sat_leave got=d%0d sat%0b exp=d2 sat0", d2, s2); end
        dir = 1'b1;
        repeat (2) tick();
        checks++;
        if (d2 !== 8'd0 || s2 !== 1'b1) begin failures++; $display("FAIL sat_again got=d%0d sat%0b exp=d0 sat1", d2, s2); end
        mode = 1'b0;
        tick();
        checks++;
        if (d2 !== 8'd0 || s2 !== 1'b0 || t2 !== 1'b0) begin failures++; $display("FAIL sat_to_wrap got=d%0d sat%0b tc%0b exp=d0 sat0 tc0", d2, s2, t2); end
        tick();
        checks++;
        if (d2 !== 8'd254 || t2 !== 1'b1) begin failures++; $display("FAIL wrap_down got=d%0d tc%0b exp=d254 tc1", d2, t2); end
    endtask

    task automatic test_disable();
        dir = 1'b0;
        mode = 1'b0;
        load = 1'b1;
        load_value = 8'd7;
        tick();
        load = 1'b0;
        enable = 1'b0;
        tick();
        checks++;
        if (d0 !== 8'd0 || v0 !== 1'b0) begin failures++; $display("FAIL dis_clear got=v%0b d%0d exp=v0 d0", v0, d0); end
        checks++;
        if (dh !== 8'd7 || vh !== 1'b0) begin failures++; $display("FAIL dis_hold got=v%0b d%0d exp=v0 d7", vh, dh); end
        enable = 1'b1;
        tick();
        checks++;
        if (dh !== 8'd7 || vh !== 1'b1) begin failures++; $display("FAIL reenable got=v%0b d%0d exp=v1 d7", vh, dh); end
        tick();
        checks++;
        if (dh !== 8'd8) begin failures++; $display("FAIL reenable_count got=%0d exp=8", dh); end
    endtask

    task automatic test_priority();
        clear = 1'b1;
        load = 1'b1;
        load_value = 8'd99;
        tick();
        clear = 1'b0;
        load = 1'b0;
        checks++;
        if (d0 !== 8'd0 || dh !== 8'd0 || t0 !== 1'b0) begin failures++; $display("FAIL clr_over_load got=%0d,%0d tc%0b exp=0,0 tc0", d0, dh, t0); end
        tick();
        checks++;
        if (d0 !== 8'd1 || v0 !== 1'b1) begin failures++; $display("FAIL clr_then_count got=v%0b d%0d exp=v1 d1", v0, d0); end
        load = 1'b1;
        load_value = 8'd250;
        tick();
        load = 1'b0;
        checks++;
        if (d0 !== 8'd250 || dh !== 8'd200) begin failures++; $display("FAIL load_clamp got=%0d,%0d exp=250,200", d0, dh); end
        tick();
        checks++;
        if (dh !== 8'd0 || th !== 1'b1) begin failures++; $display("FAIL clamp_wrap got=d%0d tc%0b exp=d0 tc1", dh, th); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_backpressure();
        test_async_reset();
        test_wrap();
        test_saturate();
        test_disable();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_bus_counter.md
PARAM_BUS_COUNTER -- requirements
Module: param_bus_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: counter and data width in bits.
REQ-002 The block SHALL have parameter STEP, default 1: increment/decrement magnitude; legal range 1..MAX_VAL.
REQ-003 The block SHALL have parameter MAX_VAL, default 2**WIDTH-1: terminal count value.
REQ-004 The block SHALL have parameter CLR_ON_DIS, default 1: 1 = data cleared to 0 whenever enable is low (legacy behaviour); 0 = data held.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  count enable.
REQ-009 clear  input  1  synchronous clear to 0.
REQ-010 load  input  1  synchronous load of load_value.
REQ-011 load_value  input  WIDTH  value to load.
REQ-012 dir  input  1  0 = count up, 1 = count down.
REQ-013 mode  input  1  0 = wrap, 1 = saturate.
REQ-014 data_ready  input  1  consumer accepts current data.
REQ-015 data  output  WIDTH  current count.
REQ-016 data_valid  output  1  data is presented for consumption.
REQ-017 tc  output  1  one-cycle pulse on wrap-around.
REQ-018 sat  output  1  level; counter is held at its limit.

Function
REQ-019 FSM states SHALL be IDLE (data_valid=0), RUN (data_valid=1) and SAT (data_valid=1, sat=1).
REQ-020 Per-edge priority SHALL be clear > load > enable-low > count.
REQ-021 clear SHALL set data=0, tc=0 and sat=0; next state SHALL be RUN if enable=1, else IDLE.
REQ-022 load SHALL set data=min(load_value, MAX_VAL) and sat=0; next state SHALL be RUN if enable=1, else IDLE.
REQ-023 enable=0 SHALL move any state to IDLE; data SHALL become 0 if CLR_ON_DIS=1, else hold.
REQ-024 IDLE with enable=1 SHALL go to RUN next edge with no data change; data_valid therefore rises one cycle after enable.
REQ-025 In RUN, data SHALL advance by STEP only on an edge where enable=1 and data_ready=1; with data_ready=0, data and data_valid SHALL hold.
REQ-026 Wrap up: if data+STEP > MAX_VAL, data SHALL become data+STEP-(MAX_VAL+1), with tc=1 for exactly that cycle.
REQ-027 Wrap down: if data < STEP, data SHALL become data+(MAX_VAL+1)-STEP, with tc=1 for exactly that cycle.
REQ-028 Saturate: on overflow, data SHALL become MAX_VAL (up) or 0 (down); state SHALL become SAT; tc SHALL stay 0.
REQ-029 SAT SHALL hold data. An accepted beat with dir away from the limit SHALL return to RUN and apply the step in the same edge. A mode change to wrap SHALL return to RUN with no step.
REQ-030 Arithmetic SHALL use WIDTH+1 bits internally; no intermediate truncation.
REQ-031 tc SHALL be 0 on every cycle other than a wrap.

Reset
REQ-032 rst_n low SHALL immediately force data=0, data_valid=0, tc=0, sat=0 and state IDLE, regardless of clk.
REQ-033 Reset deassertion mid-operation SHALL resume from IDLE; no partial count SHALL survive.

Structure
REQ-034 A shared package param_bus_counter_pkg SHALL hold the state enum (IDLE, RUN, SAT) and the mode/dir encodings.
REQ-035 Next-value arithmetic (wrap/saturate, up/down) SHALL be one combinational sub-module, pbc_next_val; FSM and registers SHALL reside in the top.
REQ-036 An elaboration-time check SHALL reject STEP=0 and STEP>MAX_VAL.

Verification (WIDTH=8, STEP=1, MAX_VAL=255 unless stated)
REQ-037 Reset: assert rst_n low mid-count at data=9 -> data=0, data_valid=0, tc=0, sat=0 without waiting for a clk edge.
REQ-038 Count: enable=1, data_ready=1 from reset -> data_valid=1 after 1 edge; data=1,2,3,4,5 on the next 5 edges.
REQ-039 Backpressure: data_ready=0 for 3 cycles at data=5 -> data stays 5, data_valid stays 1; resumes at 6.
REQ-040 Wrap: load 254, mode=0, dir=0 -> data 255, then 0 with tc=1 for one cycle; same test with STEP=3 and load 254 -> data 1.
REQ-041 Saturate: STEP=2, mode=1, dir=1, load 3 -> data 1, then 0 with sat=1; further beats hold 0; dir=0 -> data 2, sat=0.
REQ-042 Disable and priority: enable=0 at data=7 -> data 0, data_valid 0 (CLR_ON_DIS=1) or data 7 held (CLR_ON_DIS=0); clear and load asserted together -> data=0.
